// File: rtl/pipe_skid_chain_pkg.sv
// Shared constants and helpers for the pipe_skid_chain register chain.
package pipe_skid_chain_pkg;

    localparam int unsigned DEF_BITWIDTH   = 4;
    localparam int unsigned DEF_DEPTH      = 2;
    localparam int unsigned DEF_RESET_DATA = 0;

    // Width needed to count 0..depth occupied stages
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// One stage of the chain: valid bit plus data register with load control.
module pipe_skid_stage
    import pipe_skid_chain_pkg::*;
#(
    parameter int unsigned             BITWIDTH   = DEF_BITWIDTH,
    parameter logic [BITWIDTH-1:0]     RESET_DATA = BITWIDTH'(DEF_RESET_DATA)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                load_i,
    input  logic                valid_i,
    input  logic [BITWIDTH-1:0] data_i,
    output logic                valid_o,
    output logic [BITWIDTH-1:0] data_o
);

    // Valid follows the upstream stage on load; flush wins. Data only moves
    // with a valid word so bubbles leave the previous payload in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o <= 1'b0;
            data_o  <= RESET_DATA;
        end else begin
            if (flush_i) begin
                valid_o <= 1'b0;
            end else if (load_i) begin
                valid_o <= valid_i;
            end
            if (!flush_i && load_i && valid_i) begin
                data_o <= data_i;
            end
        end
    end

endmodule

// File: rtl/pipe_skid_chain.sv
// Chain of DEPTH valid/ready register stages with bubble collapse and flush.
module pipe_skid_chain
    import pipe_skid_chain_pkg::*;
#(
    parameter int unsigned         BITWIDTH   = DEF_BITWIDTH,
    parameter int unsigned         DEPTH      = DEF_DEPTH,
    parameter logic [BITWIDTH-1:0] RESET_DATA = BITWIDTH'(DEF_RESET_DATA)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush_i,
    input  logic                            valid_i,
    output logic                            ready_o,
    input  logic [BITWIDTH-1:0]             data_i,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [BITWIDTH-1:0]             data_o,
    output logic [count_width(DEPTH)-1:0]   count_o
);

    localparam int unsigned CW = count_width(DEPTH);

    logic [DEPTH-1:0]    v_q;
    logic [BITWIDTH-1:0] d_q [DEPTH];
    logic [DEPTH:0]      rdy;
    logic                in_xfer;
    logic                out_xfer;

    // Readiness ripples from the output back toward the input; an empty
    // stage is always ready, which lets bubbles collapse.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = ready_i;
        for (int unsigned i = DEPTH; i > 0; i--) begin
            rdy[i-1] = ~v_q[i-1] | rdy[i];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic                v_in;
        logic [BITWIDTH-1:0] d_in;
        if (k == 0) begin : g_head
            assign v_in = valid_i;
            assign d_in = data_i;
        end else begin : g_body
            assign v_in = v_q[k-1];
            assign d_in = d_q[k-1];
        end

        pipe_skid_stage #(
            .BITWIDTH   (BITWIDTH),
            .RESET_DATA (RESET_DATA)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .flush_i (flush_i),
            .load_i  (rdy[k]),
            .valid_i (v_in),
            .data_i  (d_in),
            .valid_o (v_q[k]),
            .data_o  (d_q[k])
        );
    end

    // While in reset only the tail is considered feedable, so ready mirrors
    // the downstream ready; a flush cycle always advertises ready.
    assign ready_o  = rst ? ready_i : (flush_i | rdy[0]);
    assign valid_o  = v_q[DEPTH-1];
    assign data_o   = d_q[DEPTH-1];
    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = valid_o & ready_i;

    // Occupancy tracks handshakes at both ends; flush empties the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_o <= '0;
        end else if (flush_i) begin
            count_o <= '0;
        end else begin
            count_o <= count_o + CW'(in_xfer) - CW'(out_xfer);
        end
    end

endmodule

// File: tb/tb_pipe_skid_chain.sv
// Directed bench for pipe_skid_chain (DEPTH=3) plus a DEPTH=1 random run.
module tb_pipe_skid_chain;

    localparam logic [7:0] RST_DATA = 8'hC3;

    logic       clk = 1'b0;
    logic       rst;

    // DEPTH=3 instance
    logic       flush_a, valid_a, ready_a, ready_oa, valid_oa;
    logic [7:0] data_a, data_oa;
    logic [1:0] count_oa;

    // DEPTH=1 instance
    logic       flush_b, valid_b, ready_b, ready_ob, valid_ob;
    logic [7:0] data_b, data_ob;
    logic [0:0] count_ob;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    pipe_skid_chain #(
        .BITWIDTH   (8),
        .DEPTH      (3),
        .RESET_DATA (RST_DATA)
    ) dut_a (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_a),
        .valid_i (valid_a),
        .ready_o (ready_oa),
        .data_i  (data_a),
        .valid_o (valid_oa),
        .ready_i (ready_a),
        .data_o  (data_oa),
        .count_o (count_oa)
    );

    pipe_skid_chain #(
        .BITWIDTH   (8),
        .DEPTH      (1),
        .RESET_DATA (RST_DATA)
    ) dut_b (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_b),
        .valid_i (valid_b),
        .ready_o (ready_ob),
        .data_i  (data_b),
        .valid_o (valid_ob),
        .ready_i (ready_b),
        .data_o  (data_ob),
        .count_o (count_ob)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_d;
        logic       m_rdy;

        rst = 1'b1;
        flush_a = 0; valid_a = 0; ready_a = 0; data_a = '0;
        flush_b = 0; valid_b = 0; ready_b = 0; data_b = '0;

        // Reset state
        #2;
        check("rst_valid", valid_oa, 0);
        check("rst_data", data_oa, RST_DATA);
        check("rst_count", count_oa, 0);
        check("rst_ready_lo", ready_oa, 0);
        ready_a = 1;
        #1;
        check("rst_ready_hi", ready_oa, 1);
        step();
        step();
        rst = 1'b0;

        // Latency and throughput
        ready_a = 1; valid_a = 1; data_a = 8'h11;
        step();
        check("lat_v0", valid_oa, 0);
        check("lat_c0", count_oa, 1);
        data_a = 8'h22;
        step();
        check("lat_v1", valid_oa, 0);
        check("lat_c1", count_oa, 2);
        data_a = 8'h33;
        step();
        check("lat_v2", valid_oa, 1);
        check("lat_d11", data_oa, 8'h11);
        check("lat_c2", count_oa, 3);
        valid_a = 0;
        step();
        check("lat_d22", data_oa, 8'h22);
        check("lat_c3", count_oa, 2);
        step();
        check("lat_d33", data_oa, 8'h33);
        check("lat_c4", count_oa, 1);
        step();
        check("lat_empty", valid_oa, 0);
        check("lat_c5", count_oa, 0);
        check("bubble_hold", data_oa, 8'h33);

        // Fill with downstream stalled, then simultaneous pop/push
        ready_a = 0; valid_a = 1; data_a = 8'hA0;
        step();
        data_a = 8'hA1;
        step();
        data_a = 8'hA2;
        step();
        data_a = 8'hA3;
        #1;
        check("full_count", count_oa, 3);
        check("full_ready", ready_oa, 0);
        step();
        check("stall_data", data_oa, 8'hA0);
        check("stall_valid", valid_oa, 1);
        check("stall_count", count_oa, 3);
        ready_a = 1;
        #1;
        check("pp_ready", ready_oa, 1);
        step();
        check("pp_data", data_oa, 8'hA1);
        check("pp_count", count_oa, 3);
        valid_a = 0;
        step();
        check("dr_a2", data_oa, 8'hA2);
        check("dr_c2", count_oa, 2);
        step();
        check("dr_a3", data_oa, 8'hA3);
        check("dr_c1", count_oa, 1);
        step();
        check("dr_empty", valid_oa, 0);

        // Bubble collapse: lone word in the tail, downstream stalled
        ready_a = 0; valid_a = 1; data_a = 8'h5A;
        step();
        valid_a = 0;
        step();
        step();
        check("bc_count1", count_oa, 1);
        check("bc_data5a", data_oa, 8'h5A);
        valid_a = 1; data_a = 8'h6B;
        #1;
        check("bc_ready", ready_oa, 1);
        step();
        valid_a = 0;
        check("bc_count2", count_oa, 2);
        step();
        check("bc_stable", data_oa, 8'h5A);
        check("bc_valid", valid_oa, 1);
        ready_a = 1;
        step();
        check("bc_data6b", data_oa, 8'h6B);
        check("bc_count3", count_oa, 1);
        step();
        check("bc_empty", count_oa, 0);

        // Flush of a full chain with a concurrent push
        ready_a = 0; valid_a = 1; data_a = 8'hC1;
        step();
        data_a = 8'hC2;
        step();
        data_a = 8'hC3;
        step();
        check("fl_full", count_oa, 3);
        flush_a = 1; data_a = 8'hFF;
        #1;
        check("fl_ready", ready_oa, 1);
        check("fl_valid_pre", valid_oa, 1);
        check("fl_data_pre", data_oa, 8'hC1);
        step();
        flush_a = 0; valid_a = 0;
        check("fl_count", count_oa, 0);
        check("fl_valid", valid_oa, 0);
        ready_a = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("fl_no_ff", valid_oa, 0);
        end

        // Reset mid-stream, between edges
        ready_a = 0; valid_a = 1; data_a = 8'hD1;
        step();
        data_a = 8'hD2;
        step();
        valid_a = 0;
        check("mr_count2", count_oa, 2);
        #2;
        rst = 1'b1;
        #1;
        check("mr_valid", valid_oa, 0);
        check("mr_data", data_oa, RST_DATA);
        check("mr_count", count_oa, 0);
        #2;
        rst = 1'b0;
        ready_a = 1; valid_a = 1; data_a = 8'h01;
        step();
        valid_a = 0;
        check("mr_lat0", valid_oa, 0);
        step();
        check("mr_lat1", valid_oa, 0);
        step();
        check("mr_lat2", valid_oa, 1);
        check("mr_data01", data_oa, 8'h01);
        step();
        check("mr_done", valid_oa, 0);

        // DEPTH=1 random traffic against a queue model
        for (int i = 0; i < 1000; i++) begin
            valid_b = 1'($urandom_range(0, 1));
            ready_b = 1'($urandom_range(0, 1));
            data_b  = 8'($urandom);
            #1;
            m_rdy = (q.size() == 0) || ready_b;
            check("d1_count", count_ob, q.size());
            check("d1_valid", valid_ob, (q.size() != 0));
            check("d1_ready", ready_ob, m_rdy);
            if (q.size() != 0 && ready_b) begin
                exp_d = q.pop_front();
                check("d1_data", data_ob, exp_d);
            end
            if (valid_b && m_rdy) begin
                q.push_back(data_b);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_skid_chain.md
PIPE_SKID_CHAIN -- requirements
Module: pipe_skid_chain

Interface
REQ-001 Parameter BITWIDTH, default 4: width of the data payload in bits, legal values 1 or more.
REQ-002 Parameter DEPTH, default 2: number of register stages, legal values 1 or more.
REQ-003 Parameter RESET_DATA, default 0: value loaded into every data register on reset, BITWIDTH bits wide.
REQ-004 Port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port flush_i, input, 1 bit: synchronous flush of all stages.
REQ-007 Port valid_i, input, 1 bit: upstream has a word to offer.
REQ-008 Port ready_o, output, 1 bit: the block can accept a word this cycle.
REQ-009 Port data_i, input, BITWIDTH bits: upstream payload.
REQ-010 Port valid_o, output, 1 bit: the last stage holds a valid word.
REQ-011 Port ready_i, input, 1 bit: downstream accepts the word this cycle.
REQ-012 Port data_o, output, BITWIDTH bits: payload held in the last stage.
REQ-013 Port count_o, output, clog2(DEPTH+1) bits: number of stages currently holding a valid word.

Function
REQ-014 Each stage k (k = 0 to DEPTH-1) SHALL hold a valid bit v[k] and a data register d[k]; stage 0 faces the input and stage DEPTH-1 drives valid_o and data_o.
REQ-015 Readiness SHALL be computed combinationally as rdy[k] = ~v[k] | rdy[k+1], with rdy[DEPTH] = ready_i and ready_o = rdy[0], so that empty stages (bubbles) collapse.
REQ-016 Stage k SHALL load when rdy[k] = 1: d[k] takes d[k-1] (data_i for k = 0) and v[k] takes v[k-1] (valid_i for k = 0).
REQ-017 d[k] SHALL change only when stage k loads a valid word; it SHALL hold its value otherwise, including when a bubble is loaded.
REQ-018 A transfer SHALL occur at the input when valid_i & ready_o are both 1, and at the output when valid_o & ready_i are both 1.
REQ-019 Latency through an empty chain with ready_i held at 1 SHALL be exactly DEPTH cycles; throughput SHALL be one word per cycle, with no bubble inserted in steady state.
REQ-020 While valid_o = 1 and ready_i = 0, data_o and valid_o SHALL remain stable.
REQ-021 Words SHALL leave in the order they were accepted; none SHALL be dropped or duplicated except by a flush.
REQ-022 Full condition: when count_o = DEPTH and ready_i = 0, ready_o SHALL be 0.
REQ-023 Simultaneous pop and push when full (ready_i = 1 and valid_i = 1) SHALL accept the new word in the same cycle and leave count_o unchanged.
REQ-024 count_o SHALL be registered, and its next value SHALL equal the current value plus the input transfer minus the output transfer.
REQ-025 When flush_i = 1, all v[k] SHALL be cleared at the next edge and count_o SHALL become 0.
REQ-026 An input handshake in the same cycle as a flush SHALL be discarded, and flush SHALL take priority over any concurrent load.
REQ-027 During a flush cycle ready_o SHALL read 1 and valid_o SHALL reflect the pre-flush state; the d[k] registers are not cleared by a flush.
REQ-028 With DEPTH = 1 the block SHALL behave as a single register slice with a combinational ready path (ready_o = ~v[0] | ready_i).

Reset
REQ-029 On rst = 1, asynchronously and without waiting for clk: all v[k] = 0, every d[k] = RESET_DATA, count_o = 0.
REQ-030 While rst = 1, the outputs SHALL be valid_o = 0, data_o = RESET_DATA and ready_o = ready_i (only stage DEPTH-1 can be fed).
REQ-031 Reset asserted mid-stream SHALL discard all in-flight words, and the first edge after rst deasserts SHALL operate normally.

Structure
REQ-032 A shared package SHALL hold the count-width function (clog2 of DEPTH+1) and the default parameter constants.
REQ-033 One sub-module, pipe_skid_stage, SHALL implement a single stage (valid bit, data register, load logic) and be instantiated DEPTH times in a generate loop.
REQ-034 The readiness chain and count_o SHALL reside in the top level.

Verification
REQ-035 DEPTH=3, BITWIDTH=8, ready_i = 1, push 0x11, 0x22, 0x33 on consecutive cycles -> valid_o rises 3 cycles after the first push, and data_o shows 0x11, 0x22, 0x33 on consecutive cycles.
REQ-036 DEPTH=3, ready_i = 0, push 4 words 0xA0..0xA3 -> 0xA0..0xA2 accepted, count_o = 3, ready_o = 0, 0xA3 held at the input; then raise ready_i -> 0xA3 accepted the same cycle 0xA0 pops.
REQ-037 DEPTH=3, word 0x5A in stage 2 only, ready_i = 0, push 0x6B -> ready_o = 1 (bubble collapse) and 0x6B reaches stage 1 within 2 cycles.
REQ-038 DEPTH=3, full chain, assert flush_i with valid_i = 1 and data_i = 0xFF -> next cycle count_o = 0 and valid_o = 0, and 0xFF never appears at data_o.
REQ-039 Assert rst between clock edges while count_o = 2 -> valid_o = 0 and data_o = RESET_DATA immediately; after release, push 0x01 -> emerges after exactly DEPTH cycles.
REQ-040 DEPTH=1, random valid_i/ready_i for 1000 cycles -> scoreboard shows in-order, lossless delivery and that count_o always equals valid_o.
